// File: rtl/sensor_ultrasonido_if.sv
// Signal bundle between a ranging initiator (master) and the emulated
// ultrasonic sensor (slave).
interface sensor_ultrasonido_if;
    logic        Enable;
    logic        Trigger;
    logic [15:0] echo_us;
    logic        Echo;
    logic        busy;
    logic        trig_err;
    logic [7:0]  contador_echos;

    modport master (
        output Enable, Trigger, echo_us,
        input  Echo, busy, trig_err, contador_echos
    );

    modport slave (
        input  Enable, Trigger, echo_us,
        output Echo, busy, trig_err, contador_echos
    );
endinterface

// File: rtl/sensor_ultrasonido.sv
// Ultrasonic ranging sensor emulator: validates a trigger pulse, waits out the
// burst delay, then drives an echo pulse of the programmed width.
module sensor_ultrasonido #(
    parameter int TICK_DIV    = 50,
    parameter int TRIG_MIN_US = 8,
    parameter int BURST_US    = 200,
    parameter int ECHO_MAX_US = 38000,
    parameter int HOLDOFF_US  = 60
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sensor_ultrasonido_if.slave  sif
);
    localparam int               CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [4:0]       TRIG_MIN   = 5'(TRIG_MIN_US);
    localparam logic [15:0]      BURST_LAST = 16'(BURST_US - 1);
    localparam logic [15:0]      HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0]      ECHO_MAX   = 16'(ECHO_MAX_US);

    typedef enum logic [2:0] {IDLE, ARM, BURST, ECHO, HOLDOFF} state_t;

    state_t           state;
    logic             trig_m, trig_s, trig_d;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick, rise, fall;
    logic [4:0]       trig_cnt;
    logic [15:0]      timer, width;

    // A zero or out-of-range request means "no object": use the maximum width.
    function automatic logic [15:0] clamp_width(input logic [15:0] req);
        return (req == 16'd0 || req > ECHO_MAX) ? ECHO_MAX : req;
    endfunction

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    assign tick = (tick_cnt == TICK_LAST);
    assign rise = trig_s & ~trig_d;
    assign fall = ~trig_s & trig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_m   <= 1'b0;
            trig_s   <= 1'b0;
            trig_d   <= 1'b0;
            tick_cnt <= '0;
        end else begin
            trig_m   <= sif.Trigger;
            trig_s   <= trig_m;
            trig_d   <= trig_s;
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            trig_cnt           <= '0;
            timer              <= '0;
            width              <= '0;
            sif.Echo           <= 1'b0;
            sif.busy           <= 1'b0;
            sif.trig_err       <= 1'b0;
            sif.contador_echos <= '0;
        end else begin
            sif.trig_err <= 1'b0;
            if (!sif.Enable) begin
                state    <= IDLE;
                sif.Echo <= 1'b0;
                sif.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state    <= ARM;
                            trig_cnt <= '0;
                            sif.busy <= 1'b1;
                        end
                    end
                    ARM: begin
                        if (fall) begin
                            if (trig_cnt >= TRIG_MIN) begin
                                width <= clamp_width(sif.echo_us);
                                timer <= '0;
                                state <= BURST;
                            end else begin
                                sif.trig_err <= 1'b1;
                                sif.busy     <= 1'b0;
                                state        <= IDLE;
                            end
                        end else if (tick && trig_s) begin
                            trig_cnt <= sat_inc(trig_cnt);
                        end
                    end
                    BURST: begin
                        if (tick) begin
                            if (timer == BURST_LAST) begin
                                timer    <= '0;
                                state    <= ECHO;
                                sif.Echo <= 1'b1;
                            end else begin
                                timer <= timer + 16'd1;
                            end
                        end
                    end
                    ECHO: begin
                        // Entered on a tick edge, so the pulse spans exactly width ticks.
                        if (tick) begin
                            if (timer == width - 16'd1) begin
                                timer              <= '0;
                                state              <= HOLDOFF;
                                sif.Echo           <= 1'b0;
                                sif.contador_echos <= sif.contador_echos + 8'd1;
                            end else begin
                                timer <= timer + 16'd1;
                            end
                        end
                    end
                    HOLDOFF: begin
                        if (tick) begin
                            if (timer == HOLD_LAST) begin
                                timer    <= '0;
                                state    <= IDLE;
                                sif.busy <= 1'b0;
                            end else begin
                                timer <= timer + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        sif.Echo <= 1'b0;
                        sif.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sensor_ultrasonido.sv
// Directed bench for sensor_ultrasonido with shortened timing parameters
// (2 clk per tick) so full measurements fit in a short run.
module tb_sensor_ultrasonido;
    localparam int TD    = 2;
    localparam int TMIN  = 8;
    localparam int BURST = 10;
    localparam int EMAX  = 300;
    localparam int HOLD  = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   err_pulses = 0;

    sensor_ultrasonido_if sif();

    sensor_ultrasonido #(
        .TICK_DIV(TD), .TRIG_MIN_US(TMIN), .BURST_US(BURST),
        .ECHO_MAX_US(EMAX), .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sif(sif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sif.trig_err === 1'b1) err_pulses++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_trig(input int cyc);
        @(negedge clk);
        sif.Trigger = 1'b1;
        repeat (cyc) @(negedge clk);
        sif.Trigger = 1'b0;
    endtask

    // Negedges until Echo is seen high; -1 on timeout.
    task automatic wait_echo(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sif.Echo === 1'b1) begin
                n = i;
                return;
            end
        end
    endtask

    // Called while Echo is high; total negedges seen high, counting from start.
    task automatic echo_width(input int start, input int limit, output int n);
        n = start;
        while (n <= limit) begin
            @(negedge clk);
            if (sif.Echo !== 1'b1) return;
            n++;
        end
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sif.busy === 1'b0) begin
                n = i;
                return;
            end
        end
    endtask

    initial begin
        int d, w, n, e0, tmo;
        sif.Enable  = 1'b0;
        sif.Trigger = 1'b0;
        sif.echo_us = 16'd100;
        repeat (3) @(negedge clk);
        chk("rst_echo", sif.Echo, 0);
        chk("rst_busy", sif.busy, 0);
        chk("rst_err", sif.trig_err, 0);
        chk("rst_count", sif.contador_echos, 0);
        rst_n = 1'b1;
        sif.Enable = 1'b1;
        repeat (2) @(negedge clk);

        // Valid 10-tick trigger; echo_us changed after the latch must not matter
        pulse_trig(20);
        repeat (6) @(negedge clk);
        sif.echo_us = 16'd7;
        wait_echo(100, d);
        chk_rng("burst_delay", (d < 0) ? d : d + 6, BURST*TD - TD, BURST*TD + TD + 3);
        chk("busy_in_echo", sif.busy, 1);
        echo_width(1, 1000, w);
        chk("width_100", w, 200);
        chk("count_1", sif.contador_echos, 1);
        chk("busy_holdoff", sif.busy, 1);
        wait_idle(200, n);
        chk_rng("holdoff_len", n, HOLD*TD - 1, HOLD*TD + 1);

        // 7-tick trigger is rejected with a single trig_err pulse
        sif.echo_us = 16'd100;
        e0 = err_pulses;
        pulse_trig(14);
        repeat (20) @(negedge clk);
        chk("short_err", err_pulses - e0, 1);
        chk("short_busy", sif.busy, 0);
        chk("short_echo", sif.Echo, 0);
        chk("short_count", sif.contador_echos, 1);

        // 9-tick trigger accepted; triggers during ECHO and HOLDOFF ignored
        e0 = err_pulses;
        pulse_trig(18);
        wait_echo(100, d);
        chk_rng("min_trig_delay", d, BURST*TD - TD, BURST*TD + TD + 3);
        repeat (20) @(negedge clk);
        pulse_trig(20);
        echo_width(42, 1000, w);
        chk("width_trig_in_echo", w, 200);
        repeat (30) @(negedge clk);
        pulse_trig(20);
        wait_idle(200, n);
        chk_rng("holdoff_with_trig", n, HOLD*TD - 51 - 1, HOLD*TD - 51 + 1);
        repeat (60) @(negedge clk);
        chk("ignored_busy", sif.busy, 0);
        chk("ignored_count", sif.contador_echos, 2);
        chk("ignored_err", err_pulses - e0, 0);

        pulse_trig(20);
        wait_echo(100, d);
        chk_rng("after_hold_delay", d, BURST*TD - TD, BURST*TD + TD + 3);
        echo_width(1, 1000, w);
        wait_idle(200, n);
        chk("after_hold_count", sif.contador_echos, 3);

        // Width clamping: zero and oversize requests give the maximum
        sif.echo_us = 16'd0;
        pulse_trig(20);
        wait_echo(100, d);
        echo_width(1, 2000, w);
        chk("width_zero", w, EMAX*TD);
        wait_idle(200, n);
        sif.echo_us = 16'd400;
        pulse_trig(20);
        wait_echo(100, d);
        echo_width(1, 2000, w);
        chk("width_over", w, EMAX*TD);
        wait_idle(200, n);
        chk("clamp_count", sif.contador_echos, 5);

        // Enable dropped mid-ECHO
        sif.echo_us = 16'd100;
        e0 = err_pulses;
        pulse_trig(20);
        wait_echo(100, d);
        repeat (10) @(negedge clk);
        sif.Enable = 1'b0;
        @(negedge clk);
        chk("dis_echo", sif.Echo, 0);
        chk("dis_busy", sif.busy, 0);
        chk("dis_count", sif.contador_echos, 5);

        // Trigger already high when Enable rises does not start a measurement
        sif.Trigger = 1'b1;
        repeat (5) @(negedge clk);
        sif.Enable = 1'b1;
        repeat (10) @(negedge clk);
        sif.Trigger = 1'b0;
        repeat (60) @(negedge clk);
        chk("en_high_busy", sif.busy, 0);
        chk("en_high_count", sif.contador_echos, 5);
        chk("en_high_err", err_pulses - e0, 0);

        // Asynchronous reset mid-ECHO
        pulse_trig(20);
        wait_echo(100, d);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_echo", sif.Echo, 0);
        chk("arst_busy", sif.busy, 0);
        chk("arst_count", sif.contador_echos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_resume_busy", sif.busy, 0);
        chk("arst_no_resume_echo", sif.Echo, 0);

        // Counter wrap after 256 one-tick echoes
        sif.echo_us = 16'd1;
        tmo = 0;
        for (int i = 0; i < 256; i++) begin
            pulse_trig(20);
            wait_echo(100, d);
            if (d < 0) tmo++;
            wait_idle(300, n);
            if (n < 0) tmo++;
            if (i == 254) chk("count_255", sif.contador_echos, 255);
        end
        chk("wrap_timeouts", tmo, 0);
        chk("count_wrap", sif.contador_echos, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sensor_ultrasonido.md
SENSOR_ULTRASONIDO -- requirements
Module: sensor_ultrasonido

Interface
REQ-001 Parameter TICK_DIV, default 50: clk cycles per 1 us tick (50 MHz clk).
REQ-002 Parameter TRIG_MIN_US, default 8: minimum trigger high time, in ticks, that is accepted.
REQ-003 Parameter BURST_US, default 200: delay in ticks from trigger fall to echo rise, emulating the 8-cycle 40 kHz burst.
REQ-004 Parameter ECHO_MAX_US, default 38000: no-object echo width in ticks.
REQ-005 Parameter HOLDOFF_US, default 60: dead time in ticks after echo fall.
REQ-006 clk  input  1  system clock; the block uses this one clock only.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 Enable  input  1  block enable.
REQ-009 Trigger  input  1  trigger pulse from the ranging initiator; asynchronous to clk.
REQ-010 echo_us  input  16  programmed echo width in us; sampled once per measurement.
REQ-011 Echo  output  1  emulated sensor echo pulse, registered.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 trig_err  output  1  one-cycle pulse when a trigger is rejected as too short.
REQ-014 contador_echos  output  8  count of completed echo pulses.

Function
REQ-015 Trigger shall pass through a 2-flop synchronizer (trig_s); all edge detection shall use trig_s and its 1-cycle delayed copy.
REQ-016 The tick counter shall run 0..TICK_DIV-1 continuously, asserting tick for one cycle when it equals TICK_DIV-1, then wrapping to 0.
REQ-017 The state machine shall have the states IDLE, ARM, BURST, ECHO and HOLDOFF.
REQ-018 IDLE: on a trig_s rising edge with Enable=1, the block shall go to ARM and clear trig_cnt.
REQ-019 ARM: trig_cnt (5 bits, saturating at 31) shall increment on each tick while trig_s=1.
REQ-020 ARM, trig_s falling edge with trig_cnt>=TRIG_MIN_US: the block shall latch the width, clear the timer, and go to BURST.
REQ-021 ARM, trig_s falling edge with trig_cnt<TRIG_MIN_US: the block shall pulse trig_err for 1 cycle and go to IDLE.
REQ-022 Width latch: echo_us=0 or echo_us>ECHO_MAX_US shall latch ECHO_MAX_US; otherwise echo_us is latched unchanged.
REQ-023 BURST: the timer shall count ticks; on the tick where the timer reaches BURST_US-1, the block shall go to ECHO and clear the timer.
REQ-024 ECHO: Echo shall be 1 for exactly latched-width ticks (±1 clk); on the final tick the block shall go to HOLDOFF and increment contador_echos.
REQ-025 contador_echos shall wrap from 255 to 0.
REQ-026 HOLDOFF: Echo=0; after HOLDOFF_US ticks the block shall return to IDLE.
REQ-027 Trigger edges in BURST, ECHO or HOLDOFF shall be ignored, with no trig_err and no restart.
REQ-028 Echo shall be high only in ECHO.
REQ-029 Enable=0 in any state shall force IDLE on the next clk, with Echo=0 and no count increment; trig_err shall not pulse.
REQ-030 A trigger already high when Enable rises (no rising edge seen) shall not start a measurement.
REQ-031 A change of echo_us after the latch shall not affect the current pulse.

Reset
REQ-032 rst_n=0 shall immediately force IDLE, Echo=0, busy=0, trig_err=0, contador_echos=0, all counters 0 and synchronizer flops 0.
REQ-033 Deasserting rst_n mid-pulse shall not resume the pulse; operation restarts from IDLE.

Verification
REQ-034 Enable=1, echo_us=1000, 10 us trigger -> Echo rises 200 us (±1 tick) after trigger fall, stays high 1000 us, contador_echos=1.
REQ-035 A 5 us trigger -> one trig_err pulse, Echo stays 0, busy returns to 0.
REQ-036 echo_us=0, then echo_us=40000 -> Echo width 38000 us in both cases.
REQ-037 Trigger pulsed during ECHO, and again 30 us into HOLDOFF -> both ignored; a trigger after HOLDOFF is accepted.
REQ-038 rst_n pulsed low mid-ECHO -> Echo=0 within the same cycle, contador_echos=0, state IDLE.
REQ-039 256 valid measurements with echo_us=1 -> contador_echos wraps to 0.
